// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Holds the data/op/count widths, the 3-bit op-code constants
// and the FSM state encoding used by alu_arbiter and alu_exec.
package alu_arbiter_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned OP_CNT_W = 16;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_SLT = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_exec.sv
// alu_exec: purely combinational 32-bit ALU.
// Ports:
//   a, b   : operands (SrcA, SrcB)
//   op     : 3-bit control code
//   result : ALU result (0 for unsupported codes)
//   zero   : result == 0
//   err    : op code unsupported
module alu_exec
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              err
);

    // Operation decode; add/sub wrap naturally at 32 bits, slt is unsigned.
    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_SLT:  result = (a < b) ? DATA_W'(1) : '0;
            default: err    = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU. One op is accepted in
// IDLE, executed in EXEC and held in RESP until the consumer takes it.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   reqN_valid/ready      : requester handshake (ready is combinational)
//   reqN_a/b/op           : requester operands and op code
//   rsp_valid/ready       : response handshake
//   rsp_result/zero/src/err : registered response payload
//   busy                  : FSM not in IDLE
//   op_count              : completed operations, wraps
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [DATA_W-1:0]   req0_a,
    input  logic [DATA_W-1:0]   req0_b,
    input  logic [OP_W-1:0]     req0_op,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [DATA_W-1:0]   req1_a,
    input  logic [DATA_W-1:0]   req1_b,
    input  logic [OP_W-1:0]     req1_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic                rsp_zero,
    output logic                rsp_src,
    output logic                rsp_err,
    output logic                busy,
    output logic [OP_CNT_W-1:0] op_count
);

    state_e state, state_nxt;

    logic              last_grant;
    logic              grant;
    logic              any_valid;
    logic              accept;
    logic              exec_load;
    logic              rsp_take;

    logic [DATA_W-1:0] lat_a, lat_b;
    logic [OP_W-1:0]   lat_op;
    logic              lat_src;

    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_err;

    assign any_valid = req0_valid | req1_valid;

    // Grant selection: contention resolved by fairness mode, otherwise the lone requester.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = FAIR ? ~last_grant : 1'b0;
        end else begin
            grant = ~req0_valid;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_valid) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output/strobe decode; readys are forced low while reset is asserted.
    always_comb begin
        accept     = 1'b0;
        exec_load  = 1'b0;
        rsp_take   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                accept     = any_valid;
                req0_ready = rst_n & any_valid & ~grant;
                req1_ready = rst_n & any_valid & grant;
            end
            ST_EXEC: exec_load = 1'b1;
            ST_RESP: rsp_take  = rsp_ready;
            default: ;
        endcase
    end

    alu_exec u_exec (
        .a      (lat_a),
        .b      (lat_b),
        .op     (lat_op),
        .result (alu_result),
        .zero   (alu_zero),
        .err    (alu_err)
    );

    // Operand latches, response registers, status and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_op     <= '0;
            lat_src    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_src    <= 1'b0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                lat_a      <= grant ? req1_a  : req0_a;
                lat_b      <= grant ? req1_b  : req0_b;
                lat_op     <= grant ? req1_op : req0_op;
                lat_src    <= grant;
                last_grant <= grant;
            end
            if (exec_load) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_err    <= alu_err;
                rsp_src    <= lat_src;
            end
            if (rsp_take) begin
                op_count <= op_count + OP_CNT_W'(1);
            end
            rsp_valid <= (state_nxt == ST_RESP);
            busy      <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a FAIR=1 instance driven by tasks and
// a FAIR=0 instance with both requesters permanently valid.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_src, rsp_err, busy;
    logic [15:0] op_count;

    logic        fx_valid, fx_rsp_ready;
    logic        fx_r0_ready, fx_r1_ready;
    logic        fx_rsp_valid;
    logic [31:0] fx_rsp_result;
    logic        fx_rsp_zero, fx_rsp_src, fx_rsp_err, fx_busy;
    logic [15:0] fx_op_count;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        s;
        logic        e;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cyc = 0;
    int   exp_cnt = 0;
    int   fx_n  = 0;
    logic rv_d  = 1'b0;

    alu_arbiter #(.FAIR(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_src(rsp_src), .rsp_err(rsp_err),
        .busy(busy), .op_count(op_count)
    );

    alu_arbiter #(.FAIR(1'b0)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(fx_valid), .req0_ready(fx_r0_ready),
        .req0_a(32'd1), .req0_b(32'd2), .req0_op(3'b000),
        .req1_valid(fx_valid), .req1_ready(fx_r1_ready),
        .req1_a(32'd9), .req1_b(32'd9), .req1_op(3'b010),
        .rsp_valid(fx_rsp_valid), .rsp_ready(fx_rsp_ready),
        .rsp_result(fx_rsp_result), .rsp_zero(fx_rsp_zero),
        .rsp_src(fx_rsp_src), .rsp_err(fx_rsp_err),
        .busy(fx_busy), .op_count(fx_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [31:0] a,
                                   input logic [31:0] b, input logic [2:0] op);
        exp_t r;
        r.s = s;
        r.e = 1'b0;
        case (op)
            3'b000:  r.res = a + b;
            3'b001:  r.res = a - b;
            3'b010:  r.res = a & b;
            3'b011:  r.res = a | b;
            3'b101:  r.res = (a < b) ? 32'd1 : 32'd0;
            default: begin r.res = 32'd0; r.e = 1'b1; end
        endcase
        r.z = (r.res == 32'd0);
        return r;
    endfunction

    // Response monitor: handshake exclusivity, latency and scoreboard compare.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_ready || req1_ready) begin
                chk("rdy_onehot", 32'(req0_ready && req1_ready), 32'd0);
                acc_cyc = cyc;
            end
            if (rsp_valid && !rv_d) chk("latency", 32'(cyc - acc_cyc), 32'd2);
            if (rsp_valid && rsp_ready) begin
                chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result", rsp_result, e.res);
                    chk("zero", 32'(rsp_zero), 32'(e.z));
                    chk("src", 32'(rsp_src), 32'(e.s));
                    chk("err", 32'(rsp_err), 32'(e.e));
                    chk("op_count", 32'(op_count), 32'(exp_cnt));
                end
                exp_cnt = exp_cnt + 1;
            end
            rv_d = rsp_valid;
        end else begin
            rv_d    = 1'b0;
            exp_cnt = 0;
        end
    end

    // Fixed-priority instance: requester 0 must win every contention.
    always @(negedge clk) begin
        if (rst_n && fx_rsp_valid && fx_rsp_ready && fx_n < 3) begin
            chk("fix_src", 32'(fx_rsp_src), 32'd0);
            chk("fix_result", fx_rsp_result, 32'd3);
            fx_n = fx_n + 1;
        end
    end

    task automatic send(input logic r, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op);
        int n;
        q.push_back(model(r, a, b, op));
        @(posedge clk); #1;
        if (r) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
        else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
        n = 0;
        forever begin
            @(negedge clk);
            if ((r ? req1_ready : req0_ready) == 1'b1) break;
            n++;
            if (n > 20) begin chk("accept_timeout", 32'd1, 32'd0); break; end
        end
        @(posedge clk); #1;
        if (r) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] tab_a [8];
        logic [31:0] tab_b [8];
        logic [2:0]  tab_op[8];
        int          cnt_before;
        int          n;
        int          accepts;
        logic        exp_g;

        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        fx_valid = 1'b1; fx_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_flags", {29'd0, rsp_zero, rsp_src, rsp_err}, 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic add, then sub with zero and wrap-around results.
        send(1'b0, 32'd5, 32'd7, 3'b000);
        drain();
        chk("count_after_add", 32'(op_count), 32'd1);
        send(1'b1, 32'd3, 32'd3, 3'b001);
        send(1'b1, 32'd0, 32'd1, 3'b001);
        drain();

        // Op-code sweep including unsupported codes and unsigned compare.
        tab_a = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hF0F0_1234, 32'h0F00_0001, 32'd7, 32'd7, 32'hFFFF_FFFF};
        tab_b = '{32'd1, 32'hFFFF_FFFF, 32'd2, 32'hFF00_FF00, 32'h00F0_0000, 32'd7, 32'd7, 32'd2};
        tab_op = '{3'b110, 3'b101, 3'b101, 3'b010, 3'b011, 3'b100, 3'b111, 3'b000};
        for (int i = 0; i < 8; i++) send(1'b0, tab_a[i], tab_b[i], tab_op[i]);
        drain();

        // Backpressure: response held, no new grant, counter frozen.
        rsp_ready = 1'b0;
        send(1'b0, 32'd9, 32'd8, 3'b001);
        q.push_back(model(1'b1, 32'd4, 32'd6, 3'b000));
        req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd6; req1_op = 3'b000;
        n = 0;
        while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
        cnt_before = exp_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_result", rsp_result, 32'd1);
            chk("stall_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
            chk("stall_count", 32'(op_count), 32'(cnt_before));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        n = 0;
        while (!req1_ready && n < 20) begin @(negedge clk); n++; end
        chk("stall_req1_accept", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drain();

        // Reset while in EXEC drops the op; contention afterwards starts at requester 0.
        send(1'b0, 32'd1, 32'd1, 3'b000);
        rst_n = 1'b0;
        q.delete();
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4; req0_op = 3'b001;
        req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 3'b011;
        #1;
        chk("exec_rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        chk("exec_rst_valid", 32'(rsp_valid), 32'd0);
        chk("exec_rst_busy", 32'(busy), 32'd0);
        chk("exec_rst_count", 32'(op_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            q.push_back((i % 2 == 0) ? model(1'b0, 32'd10, 32'd4, 3'b001)
                                     : model(1'b1, 32'hF0, 32'h0F, 3'b011));
        end
        rst_n = 1'b1;
        accepts = 0; n = 0; exp_g = 1'b0;
        while (accepts < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (req0_ready || req1_ready) begin
                chk("fair_grant", 32'(req1_ready), 32'(exp_g));
                exp_g = ~exp_g;
                accepts++;
            end
        end
        chk("fair_accepts", 32'(accepts), 32'd4);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
        chk("fair_count", 32'(op_count), 32'd4);

        chk("fix_responses", 32'(fx_n), 32'd3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
